uart_byte_tx: RTL and testbench



---
 rtl/uart_byte_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_byte_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// ---------------------------------------------------------------------------
// uart_byte_tx
//
// UART byte transmitter, 8N1 framing: idle-high line, one start bit (0),
// eight data bits LSB first, one stop bit (1). Transmit partner of the
// oversampling UART byte receiver; it shares the 3-bit baud_set encoding and
// the 16x-tick divider table, so a frame sent here is received correctly by
// that receiver at the same baud_set.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the captured data bits) is sent
//   between the last data bit and the stop bit, giving an 11-bit frame.
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   send_en    in   request to transmit data_byte (ignored while busy)
//   data_byte  in   [7:0] byte to send, captured on acceptance
//   baud_set   in   [2:0] baud select, captured on acceptance
//   uart_tx    out  registered serial line, idles high
//   tx_busy    out  high while a frame is on the line
//   tx_done    out  one-cycle pulse right after the stop bit completes
// ---------------------------------------------------------------------------
module uart_byte_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       send_en,
    input  logic [7:0] data_byte,
    input  logic [2:0] baud_set,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif

    state_t      state_q, state_d;
    logic [3:0]  bitIdx_q, bitIdx_d;
    logic [15:0] divCnt_q, divCnt_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  baud_q, baud_d;
    logic        txLine_q, txLine_d;
    logic        done_q, done_d;
    logic [15:0] lastTick;

    // Divider table shared with the receiver; unused codes fall back to the
    // slowest rate.
    function automatic logic [8:0] bpsDiv(input logic [2:0] sel);
        logic [8:0] dr;
        case (sel)
            3'd0:    dr = 9'd324;
            3'd1:    dr = 9'd162;
            3'd2:    dr = 9'd80;
            3'd3:    dr = 9'd53;
            3'd4:    dr = 9'd26;
            default: dr = 9'd324;
        endcase
        return dr;
    endfunction

    // Line level for a given position in the frame.
    function automatic logic frameBit(input logic [3:0] idx, input logic [7:0] d);
        logic b;
        b = 1'b1;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd8) begin
            b = d[3'(idx - 4'd1)];
        end
`ifdef UART_TX_PARITY_EN
        else if (idx == 4'd9) begin
            b = ^d;
        end
`endif
        return b;
    endfunction

    // The divider always runs off the captured baud select, so baud_set may
    // change freely while a frame is in flight.
    assign lastTick = 16'(OVERSAMPLE) * (16'(bpsDiv(baud_q)) + 16'd1) - 16'd1;

    // Sequencing: accept in IDLE, then walk bit positions every lastTick+1
    // cycles. The line level is derived from the next state so the start
    // bit appears one cycle after the accepting edge.
    always_comb begin
        state_d  = state_q;
        bitIdx_d = bitIdx_q;
        divCnt_d = divCnt_q;
        data_d   = data_q;
        baud_d   = baud_q;
        done_d   = 1'b0;
        txLine_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (send_en) begin
                    state_d  = SEND;
                    bitIdx_d = 4'd0;
                    divCnt_d = 16'd0;
                    data_d   = data_byte;
                    baud_d   = baud_set;
                end
            end
            SEND: begin
                if (divCnt_q == lastTick) begin
                    divCnt_d = 16'd0;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d  = IDLE;
                        bitIdx_d = 4'd0;
                        done_d   = 1'b1;
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                    end
                end else begin
                    divCnt_d = divCnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == SEND) begin
            txLine_d = frameBit(bitIdx_d, data_d);
        end
    end

    // State and datapath registers; reset forces the line idle immediately
    // and drops any frame in progress without a done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            bitIdx_q <= 4'd0;
            divCnt_q <= 16'd0;
            data_q   <= 8'd0;
            baud_q   <= 3'd0;
            txLine_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitIdx_q <= bitIdx_d;
            divCnt_q <= divCnt_d;
            data_q   <= data_d;
            baud_q   <= baud_d;
            txLine_q <= txLine_d;
            done_q   <= done_d;
        end
    end

    assign uart_tx = txLine_q;
    assign tx_busy = (state_q == SEND);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_tx
//
// Directed bench for uart_byte_tx. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the active edge.
// Cycle 1 of a frame is the cycle right after the accepting edge.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
// ---------------------------------------------------------------------------
module tb_uart_byte_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rstn;
    logic       send_en;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;

    int testCount = 0;
    int failCount = 0;

    uart_byte_tx dut (
        .clk       (clk),
        .rstn      (rstn),
        .send_en   (send_en),
        .data_byte (data_byte),
        .baud_set  (baud_set),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] d, input logic [2:0] b);
        send_en   = en;
        data_byte = d;
        baud_set  = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected line level at frame position b for byte d.
    function automatic logic expBit(input int b, input logic [7:0] d);
        if (b == 0) return 1'b0;
        if (b >= 1 && b <= 8) return d[b-1];
        if (NBITS == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    // Pulse send_en across one edge; afterwards we sit in cycle 1 of the frame.
    task automatic sendByte(input logic [7:0] d, input logic [2:0] b);
        applyStimulus(1'b1, d, b);
        step(1);
        applyStimulus(1'b0, d, b);
    endtask

    // Walks a whole frame from cycle 1, checking every cycle against the
    // expected bit pattern and decoding mid-bit samples. Optionally raises
    // send_en with different data/baud between cycles disturbOn..disturbOff.
    // Ends in the cycle that should carry tx_done.
    task automatic runFrame(input string tag, input logic [7:0] d, input int bitClks,
                            input int disturbOn, input int disturbOff,
                            output logic [7:0] gotByte, output logic gotPar);
        int lineErr;
        int busyCnt;
        int doneCnt;
        lineErr = 0;
        busyCnt = 0;
        doneCnt = 0;
        gotByte = 8'h00;
        gotPar  = 1'b0;
        for (int cyc = 1; cyc <= NBITS * bitClks; cyc++) begin
            int b;
            int c;
            b = (cyc - 1) / bitClks;
            c = (cyc - 1) % bitClks;
            if (uart_tx !== expBit(b, d)) lineErr++;
            if (tx_busy === 1'b1) busyCnt++;
            if (tx_done !== 1'b0) doneCnt++;
            if (c == bitClks / 2) begin
                if (b >= 1 && b <= 8) gotByte[b-1] = uart_tx;
                if (NBITS == 11 && b == 9) gotPar = uart_tx;
            end
            if (cyc == disturbOn) applyStimulus(1'b1, 8'hFF, 3'd4);
            if (cyc == disturbOff) applyStimulus(1'b0, 8'hFF, 3'd4);
            step(1);
        end
        checkOutput({tag, " lineErrors"}, 32'(lineErr), 32'd0);
        checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'(NBITS * bitClks));
        checkOutput({tag, " earlyDone"}, 32'(doneCnt), 32'd0);
        checkOutput({tag, " doneEnd"}, {31'd0, tx_done}, 32'd1);
        checkOutput({tag, " busyEnd"}, {31'd0, tx_busy}, 32'd0);
        checkOutput({tag, " lineEnd"}, {31'd0, uart_tx}, 32'd1);
    endtask

    // Confirms the start bit lasts exactly bitClks cycles, then aborts.
    task automatic checkStartLen(input string tag, input logic [2:0] b, input int bitClks);
        sendByte(8'h01, b);
        step(bitClks - 1);
        checkOutput({tag, " startLast"}, {31'd0, uart_tx}, 32'd0);
        step(1);
        checkOutput({tag, " bit0First"}, {31'd0, uart_tx}, 32'd1);
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(1);
    endtask

    initial begin
        logic [7:0] gotByte;
        logic       gotPar;
        int         activity;

        rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 3'd0);
        step(2);
        checkOutput("reset uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("reset tx_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("reset tx_done", {31'd0, tx_done}, 32'd0);
        rstn = 1'b1;
        activity = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) activity++;
        end
        checkOutput("idle activity", 32'(activity), 32'd0);

        // 0x55 at baud_set 4: alternating line, 432 cycles per bit.
        sendByte(8'h55, 3'd4);
        checkOutput("f55 startBit", {31'd0, uart_tx}, 32'd0);
        runFrame("f55", 8'h55, 432, 0, 0, gotByte, gotPar);
        checkOutput("f55 byte", {24'd0, gotByte}, 32'h55);
        step(1);
        checkOutput("f55 doneOnce", {31'd0, tx_done}, 32'd0);

        // Back-to-back 0xA5 then 0x3C, second request in the tx_done cycle.
        sendByte(8'hA5, 3'd4);
        runFrame("fA5", 8'hA5, 432, 0, 0, gotByte, gotPar);
        checkOutput("fA5 byte", {24'd0, gotByte}, 32'hA5);
        sendByte(8'h3C, 3'd4);
        checkOutput("f3C startNoGap", {31'd0, uart_tx}, 32'd0);
        runFrame("f3C", 8'h3C, 432, 0, 0, gotByte, gotPar);
        checkOutput("f3C byte", {24'd0, gotByte}, 32'h3C);
        step(1);
        checkOutput("f3C doneOnce", {31'd0, tx_done}, 32'd0);

        // 0x0F at baud_set 2 with send_en/data/baud disturbed mid-frame.
        sendByte(8'h0F, 3'd2);
        runFrame("f0F", 8'h0F, 1296, 3000, 12000, gotByte, gotPar);
        checkOutput("f0F byte", {24'd0, gotByte}, 32'h0F);
        activity = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tx_busy !== 1'b0 || uart_tx !== 1'b1 || tx_done !== 1'b0) activity++;
        end
        checkOutput("f0F noQueuedFF", 32'(activity), 32'd0);

        // 0x81 at baud_set 3, reset during data bit 3 (frame position 4).
        sendByte(8'h81, 3'd3);
        step(4 * 864 + 299);
        checkOutput("f81 dataBit3", {31'd0, uart_tx}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("abort uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("abort tx_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("abort tx_done", {31'd0, tx_done}, 32'd0);
        step(3);
        rstn = 1'b1;
        activity = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (tx_done !== 1'b0 || tx_busy !== 1'b0) activity++;
        end
        checkOutput("abort noDone", 32'(activity), 32'd0);
        sendByte(8'h81, 3'd3);
        runFrame("f81", 8'h81, 864, 0, 0, gotByte, gotPar);
        checkOutput("f81 byte", {24'd0, gotByte}, 32'h81);

        // Remaining divider entries, including a fall-back code.
        step(1);
        checkStartLen("baud0", 3'd0, 5200);
        checkStartLen("baud1", 3'd1, 2608);
        checkStartLen("baud5", 3'd5, 5200);

`ifdef UART_TX_PARITY_EN
        sendByte(8'h07, 3'd4);
        runFrame("p07", 8'h07, 432, 0, 0, gotByte, gotPar);
        checkOutput("p07 parity", {31'd0, gotPar}, 32'd1);
        step(1);
        sendByte(8'h03, 3'd4);
        runFrame("p03", 8'h03, 432, 0, 0, gotByte, gotPar);
        checkOutput("p03 parity", {31'd0, gotPar}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
